// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer_pkg
// Purpose  : Shared state, class and opcode-group encodings for cpu_sequencer.
// Revision : 1.0
// ============================================================================
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BEQ     = 3'd3,
    CL_BNE     = 3'd4,
    CL_JUMP    = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } class_e;

  // Opcode groups live in opcode[5:1]; groups 0..7 are the arithmetic/logic/shift ops.
  localparam logic [4:0] OPC_ALU_LAST = 5'h07;
  localparam logic [4:0] OPC_LOAD     = 5'h08;
  localparam logic [4:0] OPC_STORE    = 5'h09;
  localparam logic [4:0] OPC_BEQ      = 5'h0A;
  localparam logic [4:0] OPC_BNE      = 5'h0B;
  localparam logic [4:0] OPC_JH       = 5'h0C;

  localparam int MEM_WAIT_MAX_DEF = 15;
  localparam int WAIT_W_DEF       = 4;

  function automatic class_e opcode_class(input logic [5:0] op);
    class_e cls;
    if (op[5:1] <= OPC_ALU_LAST) begin
      cls = CL_ALU;
    end else begin
      case (op[5:1])
        OPC_LOAD:  cls = CL_LOAD;
        OPC_STORE: cls = CL_STORE;
        OPC_BEQ:   cls = CL_BEQ;
        OPC_BNE:   cls = CL_BNE;
        OPC_JH:    cls = op[0] ? CL_JUMP : CL_HALT;
        default:   cls = CL_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_seq_waitcnt.sv
`default_nettype none
// ============================================================================
// Module   : cpu_seq_waitcnt
// Purpose  : Saturating memory-wait counter shared by FETCH and MEM.
// Revision : 1.0
// ============================================================================
module cpu_seq_waitcnt #(
  parameter int MAX_CNT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);

  localparam logic [CNT_W-1:0] c_sat  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_last = CNT_W'(MAX_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_sat)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the current wait cycle is the last one allowed before timeout.
  assign reached_o = (cnt_q >= c_last);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for CPU8.
//            Optional single-step gating via `CPU_SEQ_SINGLE_STEP_EN.
// Revision : 1.0
// ============================================================================
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int WAIT_W       = WAIT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [5:0] opcode,
  input  logic [5:0] ctrl_word,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_branch,
  output logic       pc_jump,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       wb_sel_mem,
  output logic [5:0] ctrl_q,
  output logic [2:0] state_o,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err
);

  state_e     state_q, state_d;
  class_e     class_q, class_d;
  logic [5:0] ctrl_d;
  logic       bus_err_q, bus_err_d;
  logic       w_wait_clr, w_wait_en, w_wait_reached;
  logic       w_fetch_go;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic armed_q, armed_d;

  // A step is only heard while idling in FETCH, so pulses mid-instruction are dropped.
  always_comb begin
    armed_d = armed_q;
    if ((state_q == ST_FETCH) && !armed_q && step) begin
      armed_d = 1'b1;
    end else if (state_d != ST_FETCH) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign w_fetch_go = armed_q;
`else
  assign w_fetch_go = 1'b1;
`endif

  cpu_seq_waitcnt #(
    .MAX_CNT (MEM_WAIT_MAX),
    .CNT_W   (WAIT_W)
  ) u_waitcnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_wait_clr),
    .en_i      (w_wait_en),
    .reached_o (w_wait_reached)
  );

  assign w_wait_clr = (state_d != state_q) || (state_q == ST_DECODE);

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    ctrl_d     = ctrl_q;
    bus_err_d  = bus_err_q;
    w_wait_en  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    wb_sel_mem = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (w_fetch_go) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end else begin
            w_wait_en = 1'b1;
            if (w_wait_reached) begin
              bus_err_d = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
      end
      ST_DECODE: begin
        ctrl_d  = ctrl_word;
        class_d = opcode_class(opcode);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        instr_done = 1'b1;
        state_d    = ST_FETCH;
        case (class_q)
          CL_ALU:   reg_wr = 1'b1;
          CL_LOAD, CL_STORE: begin
            instr_done = 1'b0;
            state_d    = ST_MEM;
          end
          CL_BEQ:   pc_branch = alu_zero;
          CL_BNE:   pc_branch = !alu_zero;
          CL_JUMP:  pc_jump = 1'b1;
          CL_HALT:  state_d = ST_HALT;
          default:  ;
        endcase
      end
      ST_MEM: begin
        mem_rd = (class_q == CL_LOAD);
        mem_wr = (class_q != CL_LOAD);
        if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end else begin
          w_wait_en = 1'b1;
          if (w_wait_reached) begin
            bus_err_d = 1'b1;
            state_d   = ST_HALT;
          end
        end
      end
      ST_WB: begin
        reg_wr     = 1'b1;
        wb_sel_mem = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_ILLEGAL;
      ctrl_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      ctrl_q    <= ctrl_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state_o = state_q;
  assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Scoreboarded random/directed bench for cpu_sequencer.
// Revision : 1.0
// ============================================================================
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] ctrl_word = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_load, pc_inc, pc_branch, pc_jump, mem_rd, mem_wr;
  logic       reg_wr, wb_sel_mem, instr_done, halted, bus_err;
  logic [5:0] ctrl_q;
  logic [2:0] state_o;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam int c_step_extra = 1;
  logic step = 1'b1;
`else
  localparam int c_step_extra = 0;
`endif

  cpu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .opcode     (opcode),
    .ctrl_word  (ctrl_word),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_branch  (pc_branch),
    .pc_jump    (pc_jump),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_wr     (reg_wr),
    .wb_sel_mem (wb_sel_mem),
    .ctrl_q     (ctrl_q),
    .state_o    (state_o),
    .instr_done (instr_done),
    .halted     (halted),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cycles;
    int         rd;
    int         wr;
    int         regw;
    int         wbm;
    int         br;
    int         jmp;
    logic [5:0] ctrl;
    int         next_state;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Whole-instruction expectation from opcode group rules, not cycle by cycle.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] cw,
                                 input bit az, input int fw, input int mw);
    exp_t e;
    int   grp;
    e = '{default: 0};
    grp = int'(op[5:1]);
    e.ctrl   = cw;
    e.rd     = fw + 1;
    e.cycles = 3 + fw + c_step_extra;
    if (grp <= 7) begin
      e.regw = 1;
    end else if (grp == 8) begin
      e.cycles += 2 + mw;
      e.rd     += mw + 1;
      e.regw    = 1;
      e.wbm     = 1;
    end else if (grp == 9) begin
      e.cycles += 1 + mw;
      e.wr      = mw + 1;
    end else if (grp == 10) begin
      e.br = az ? 1 : 0;
    end else if (grp == 11) begin
      e.br = az ? 0 : 1;
    end else if (grp == 12) begin
      if (op[0]) e.jmp = 1;
      else       e.next_state = 5;
    end
    return e;
  endfunction

  // Monitor: accumulates strobes per instruction and scores on instr_done.
  int   m_cyc, m_rd, m_wr, m_regw, m_wbm, m_br, m_jmp, m_irl, m_pci;
  bit   m_post = 1'b0;
  int   m_post_state;

  task automatic m_clear();
    m_cyc = 0; m_rd = 0; m_wr = 0; m_regw = 0; m_wbm = 0;
    m_br = 0; m_jmp = 0; m_irl = 0; m_pci = 0;
  endtask

  initial begin
    exp_t e;
    m_clear();
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        m_clear();
        m_post = 1'b0;
      end else begin
        if (m_post) begin
          chk("next_state", int'(state_o), m_post_state);
          m_post = 1'b0;
        end
        m_cyc++;
        m_rd   += int'(mem_rd);
        m_wr   += int'(mem_wr);
        m_regw += int'(reg_wr);
        m_wbm  += int'(reg_wr && wb_sel_mem);
        m_br   += int'(pc_branch);
        m_jmp  += int'(pc_jump);
        m_irl  += int'(ir_load);
        m_pci  += int'(pc_inc);
        if (instr_done) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = sb_q.pop_front();
            chk("cycles", m_cyc, e.cycles);
            chk("mem_rd_cycles", m_rd, e.rd);
            chk("mem_wr_cycles", m_wr, e.wr);
            chk("reg_wr", m_regw, e.regw);
            chk("wb_sel_mem", m_wbm, e.wbm);
            chk("pc_branch", m_br, e.br);
            chk("pc_jump", m_jmp, e.jmp);
            chk("ir_load", m_irl, 1);
            chk("pc_inc", m_pci, 1);
            chk("ctrl_q", int'(ctrl_q), int'(e.ctrl));
            m_post = 1'b1;
            m_post_state = e.next_state;
          end
          m_clear();
        end
      end
    end
  end

  // Driver: acts as a memory that answers after fw (fetch) / mw (data) waits.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] cw,
                           input bit az, input int fw, input int mw);
    int phase, acc;
    bit done, rdy, acc_on;
    sb_q.push_back(model(op, cw, az, fw, mw));
    opcode = op; ctrl_word = cw; alu_zero = az;
    phase = 0; acc = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      acc_on = mem_rd || mem_wr;
      if (acc_on) rdy = (acc == ((phase == 0) ? fw : mw));
      else        rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      #1;
      done = instr_done;
      if (acc_on) begin
        if (rdy) begin phase++; acc = 0; end
        else     acc++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (!done) fail_now("instr_timeout");
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_mem_rd"}, int'(mem_rd), 1 - c_step_extra);
    chk({tag, "_ctrl_q"}, int'(ctrl_q), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_bus_err"}, int'(bus_err), 0);
    chk({tag, "_strobes"}, int'({ir_load, pc_inc, pc_branch, pc_jump, mem_wr,
                                 reg_wr, wb_sel_mem, instr_done}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, bad, hcnt;
    logic [5:0] op;
    reset_and_check("reset");

    // Directed: ADD, LOAD with 3 data waits, BEQ/BNE with zero set, J, illegal.
    run_instr(6'h00, 6'h11, 1'b0, 0, 0);
    run_instr({5'h08, 1'b0}, 6'h22, 1'b0, 0, 3);
    run_instr({5'h0A, 1'b0}, 6'h05, 1'b1, 0, 0);
    run_instr({5'h0B, 1'b1}, 6'h06, 1'b1, 0, 0);
    run_instr({5'h0C, 1'b1}, 6'h3F, 1'b0, 1, 0);
    run_instr({5'h1F, 1'b0}, 6'h2B, 1'b0, 0, 0);
    run_instr({5'h09, 1'b1}, 6'h0C, 1'b0, 2, 4);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0, 1: op = {5'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
        2:    op = {5'h08, 1'($urandom_range(0, 1))};
        3:    op = {5'h09, 1'($urandom_range(0, 1))};
        4:    op = {5'($urandom_range(10, 11)), 1'($urandom_range(0, 1))};
        5:    op = {5'h0C, 1'b1};
        default: op = {5'($urandom_range(13, 31)), 1'($urandom_range(0, 1))};
      endcase
      run_instr(op, 6'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), $urandom_range(0, 5));
    end

    // HALT: done pulse, then sticky halted with every strobe quiet.
    run_instr({5'h0C, 1'b0}, 6'h15, 1'b0, 0, 0);
    bad = 0; hcnt = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      bad  += int'(|{ir_load, pc_inc, pc_branch, pc_jump, mem_rd, mem_wr,
                     reg_wr, wb_sel_mem, instr_done});
      hcnt += int'(halted);
      @(negedge clk);
    end
    chk("halt_strobes", bad, 0);
    chk("halt_sticky", hcnt, 20);
    reset_and_check("post_halt");

    // Fetch timeout: mem_ready never arrives.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (state_o == 3'd5) break;
      n++;
      @(negedge clk);
    end
    chk("timeout_fetch_cycles", n, 15 + c_step_extra);
    chk("timeout_bus_err", int'(bus_err), 1);
    chk("timeout_halted", int'(halted), 1);

    // Reset while a STORE sits in MEM.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    opcode = {5'h09, 1'b0};
    ctrl_word = 6'h2A;
    for (int i = 0; i < 20; i++) begin
      if (state_o == 3'd3) break;
      mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    chk("store_mem_state", int'(state_o), 3);
    chk("store_mem_wr", int'(mem_wr), 1);
    chk("store_ctrl_q", int'(ctrl_q), 'h2A);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_state", int'(state_o), 0);
    chk("abort_mem_wr", int'(mem_wr), 0);
    chk("abort_ctrl_q", int'(ctrl_q), 0);
    @(negedge clk);
    rst = 1'b0;

    chk("scoreboard_left", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
